// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants, LFSR tap table and FSM state encoding for
//               the randomised display frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Default display geometry and segment count
  localparam int DEF_WIDTH       = 120;
  localparam int DEF_HEIGHT      = 52;
  localparam int DEF_NB_SEGMENTS = 120;

  // Substitute seed used when the requested seed is all zero (LFSR lock-up)
  localparam logic [31:0] LFSR_NONZERO_SEED = 32'h0000_ACE1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Maximal-length feedback tap masks (bit i set = tap on bit i) for widths
  // 8..32; the feedback bit is the XOR of all tapped bits.
  function automatic logic [31:0] LFSR_TAPS(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_frame_seq_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_step
// Description : One combinational step of a shift-left Fibonacci LFSR plus
//               the low bits of the current state used as a random draw.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step
  import display_pkg::*;
#(
  parameter int RNDSIZE   = 16,
  parameter int PROB_BITS = 4
) (
  input  logic [RNDSIZE-1:0]   state,
  output logic [RNDSIZE-1:0]   state_nxt,
  output logic [PROB_BITS-1:0] low_bits
);

  localparam logic [31:0]        c_taps_full = LFSR_TAPS(RNDSIZE);
  localparam logic [RNDSIZE-1:0] c_taps      = c_taps_full[RNDSIZE-1:0];

  logic w_feedback;

  assign w_feedback = ^(state & c_taps);
  assign state_nxt  = {state[RNDSIZE-2:0], w_feedback};
  assign low_bits   = state[PROB_BITS-1:0];

endmodule
`default_nettype wire

// File: rtl/segment2pixel.sv
`default_nettype none
// ============================================================================
// Module      : segment2pixel
// Description : Combinational segment-to-pixel mapping; pixel p is lit by
//               segment (p mod NB_SEGMENTS).
// Revision    : 1.0 - initial release
// ============================================================================
module segment2pixel #(
  parameter int NB_SEGMENTS = 120,
  parameter int NPIX        = 6240
) (
  input  logic [NB_SEGMENTS-1:0] selseg,
  output logic [NPIX-1:0]        pix
);

  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    assign pix[p] = selseg[p % NB_SEGMENTS];
  end

endmodule
`default_nettype wire

// File: rtl/display_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : display_frame_seq
// Description : Per job, emits a run of randomised display frames. Each frame
//               masks message segments with an LFSR draw against a threshold,
//               maps them to pixels and optionally ORs in a watermark.
// Revision    : 1.0 - initial release
// ============================================================================
module display_frame_seq
  import display_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int NB_SEGMENTS   = DEF_NB_SEGMENTS,
  parameter int RNDSIZE       = 16,
  parameter int PROB_BITS     = 4,
  parameter int FRAME_CNT_W   = 8,
  parameter int HAS_WATERMARK = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RNDSIZE-1:0]        seed,
  input  logic [PROB_BITS-1:0]      prob,
  input  logic [FRAME_CNT_W-1:0]    nframes,
  input  logic [NB_SEGMENTS-1:0]    msg,
  input  logic [WIDTH*HEIGHT-1:0]   watmk,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [FRAME_CNT_W-1:0]    frame_idx,
  output logic [NB_SEGMENTS-1:0]    selseg,
  output logic [WIDTH*HEIGHT-1:0]   pix,
  output logic                      done
);

  localparam int               NPIX      = WIDTH * HEIGHT;
  localparam int               PTR_W     = $clog2(NB_SEGMENTS);
  localparam logic [PTR_W-1:0] c_lastseg = PTR_W'(NB_SEGMENTS - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [RNDSIZE-1:0]       r_lfsr;
  logic [RNDSIZE-1:0]       w_lfsr_nxt;
  logic [PROB_BITS-1:0]     w_draw;
  logic [PROB_BITS-1:0]     r_prob;
  logic [FRAME_CNT_W-1:0]   r_last_idx;
  logic [NB_SEGMENTS-1:0]   r_msg;
  logic [PTR_W-1:0]         r_ptr;
  logic [NB_SEGMENTS-1:0]   r_acc;
  logic [NB_SEGMENTS-1:0]   w_acc_nxt;
  logic [NB_SEGMENTS-1:0]   r_selseg;
  logic [NPIX-1:0]          r_pix;
  logic [NPIX-1:0]          w_segpix;
  logic [NPIX-1:0]          w_wm;
  logic [FRAME_CNT_W-1:0]   r_frame_idx;
  logic                     r_done;
  logic                     w_keep;
  logic                     w_gen_last;
  logic                     w_job_last;

  lfsr_step #(
    .RNDSIZE   (RNDSIZE),
    .PROB_BITS (PROB_BITS)
  ) u_lfsr_step (
    .state     (r_lfsr),
    .state_nxt (w_lfsr_nxt),
    .low_bits  (w_draw)
  );

  // Pixels are derived from the fully assembled mask of the current frame
  segment2pixel #(
    .NB_SEGMENTS (NB_SEGMENTS),
    .NPIX        (NPIX)
  ) u_seg2pix (
    .selseg (w_acc_nxt),
    .pix    (w_segpix)
  );

  if (HAS_WATERMARK != 0) begin : g_wm_on
    logic [NPIX-1:0] r_watmk;

    // Watermark snapshot taken when a job is accepted
    always_ff @(posedge clk) begin
      if (rst) begin
        r_watmk <= '0;
      end else if (r_state == IDLE && start) begin
        r_watmk <= watmk;
      end
    end

    assign w_wm = r_watmk;
  end else begin : g_wm_off
    assign w_wm = '0;
  end

  assign w_keep     = (w_draw >= r_prob);
  assign w_gen_last = (r_ptr == c_lastseg);
  assign w_job_last = (r_frame_idx == r_last_idx);

  // Current mask with this cycle's segment decision merged in
  always_comb begin
    w_acc_nxt        = r_acc;
    w_acc_nxt[r_ptr] = r_msg[r_ptr] & w_keep;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one GEN pass per frame, then hold in OUT until accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = GEN;
      GEN:  if (w_gen_last) w_state_nxt = OUT;
      OUT:  if (out_ready) w_state_nxt = w_job_last ? IDLE : GEN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job capture, per-segment masking, frame registration and handshake effects
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr      <= '0;
      r_prob      <= '0;
      r_last_idx  <= '0;
      r_msg       <= '0;
      r_ptr       <= '0;
      r_acc       <= '0;
      r_selseg    <= '0;
      r_pix       <= '0;
      r_frame_idx <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_lfsr      <= (seed == '0) ? LFSR_NONZERO_SEED[RNDSIZE-1:0] : seed;
            r_prob      <= prob;
            r_last_idx  <= (nframes == '0) ? '0 : nframes - 1'b1;
            r_msg       <= msg;
            r_ptr       <= '0;
            r_acc       <= '0;
            r_frame_idx <= '0;
          end
        end
        GEN: begin
          r_acc  <= w_acc_nxt;
          r_lfsr <= w_lfsr_nxt;
          if (w_gen_last) begin
            r_ptr    <= '0;
            r_selseg <= w_acc_nxt;
            r_pix    <= w_segpix | w_wm;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (w_job_last) begin
              r_done <= 1'b1;
            end else begin
              r_frame_idx <= r_frame_idx + 1'b1;
              r_ptr       <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == OUT);
  assign out_last  = (r_state == OUT) && w_job_last;
  assign frame_idx = r_frame_idx;
  assign selseg    = r_selseg;
  assign pix       = r_pix;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_display_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_frame_seq
// Description : Self-checking bench for display_frame_seq with a behavioural
//               frame model; a watermark and a no-watermark instance share
//               the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_frame_seq;

  localparam int NSEG = 120;
  localparam int NPIX = 120 * 52;
  // x^16 + x^15 + x^13 + x^4 + 1, as a mask of the tapped state bits
  localparam int POLY16 = 16'hD008;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       seed;
  logic [3:0]        prob;
  logic [7:0]        nframes;
  logic [NSEG-1:0]   msg;
  logic [NPIX-1:0]   watmk;
  logic              out_ready;
  logic              busy, out_valid, out_last, done;
  logic [7:0]        frame_idx;
  logic [NSEG-1:0]   selseg;
  logic [NPIX-1:0]   pix;
  logic              busy_n, out_valid_n, out_last_n, done_n;
  logic [7:0]        frame_idx_n;
  logic [NSEG-1:0]   selseg_n;
  logic [NPIX-1:0]   pix_n;

  int n_pass  = 0;
  int n_total = 0;
  logic [NSEG-1:0] q_exp [$];

  always #5 clk = ~clk;

  display_frame_seq #(.HAS_WATERMARK(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .prob(prob),
    .nframes(nframes), .msg(msg), .watmk(watmk), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_idx(frame_idx), .selseg(selseg), .pix(pix), .done(done)
  );

  display_frame_seq #(.HAS_WATERMARK(0)) u_dut_nowm (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .prob(prob),
    .nframes(nframes), .msg(msg), .watmk(watmk), .busy(busy_n),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_last(out_last_n),
    .frame_idx(frame_idx_n), .selseg(selseg_n), .pix(pix_n), .done(done_n)
  );

  // Run-time ceiling in case the design stops handshaking
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic chk_pix(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] exp);
    int first_diff;
    first_diff = -1;
    for (int p = NPIX - 1; p >= 0; p--) if (obs[p] !== exp[p]) first_diff = p;
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d set bits, expected %0d set bits, first differing bit %0d",
                tag, $countones(obs), $countones(exp), first_diff);
  endtask

  function automatic logic [NSEG-1:0] rand_msg();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[NSEG-1:0];
  endfunction

  function automatic logic [NPIX-1:0] rand_pix();
    logic [NPIX-1:0] r;
    for (int w = 0; w < NPIX / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Pixel p shows segment (p mod NSEG)
  function automatic logic [NPIX-1:0] seg2pix_model(input logic [NSEG-1:0] s);
    logic [NPIX-1:0] r;
    for (int p = 0; p < NPIX; p++) r[p] = s[p % NSEG];
    return r;
  endfunction

  // Expected masks of every frame of a job: one LFSR draw per segment,
  // the sequence continuing across frames of the same job
  task automatic build_model(input logic [15:0] sd, input int pr, input int eff,
                             input logic [NSEG-1:0] m);
    int s;
    int fb;
    logic [NSEG-1:0] sel;
    q_exp.delete();
    s = (sd == 16'd0) ? 'hACE1 : int'(sd);
    for (int f = 0; f < eff; f++) begin
      for (int k = 0; k < NSEG; k++) begin
        sel[k] = m[k] && ((s % 16) >= pr);
        fb = $countones(s & POLY16) % 2;
        s = ((s * 2) + fb) % 65536;
      end
      q_exp.push_back(sel);
    end
  endtask

  task automatic run_job(input logic [15:0] sd, input logic [3:0] pr, input logic [7:0] nf,
                         input logic [NSEG-1:0] m, input logic [NPIX-1:0] wm,
                         input int stall, input bit poke_start);
    int eff;
    int waited;
    logic [NSEG-1:0] es;
    logic [NPIX-1:0] ep;
    eff = (nf == 8'd0) ? 1 : int'(nf);
    build_model(sd, int'(pr), eff, m);
    seed = sd; prob = pr; nframes = nf; msg = m; watmk = wm; start = 1'b1;
    tick();
    start = 1'b0;
    // Inputs move while busy; the captured job must be unaffected
    seed = 16'($urandom); prob = 4'($urandom); nframes = 8'($urandom);
    msg = rand_msg(); watmk = ~wm;
    chk("busy_after_start", busy, 1);
    for (int f = 0; f < eff; f++) begin
      waited = 0;
      while (out_valid !== 1'b1 && waited < 4 * NSEG) begin
        start = poke_start;
        tick();
        waited++;
      end
      start = 1'b0;
      chk("frame_latency", waited, NSEG);
      if (out_valid !== 1'b1) return;
      es = q_exp[f];
      ep = seg2pix_model(es);
      chk("selseg", selseg, es);
      chk("selseg_nowm", selseg_n, es);
      chk("frame_idx", frame_idx, f);
      chk("out_last", out_last, (f == eff - 1));
      chk_pix("pix_wm", pix, ep | wm);
      chk_pix("pix_nowm", pix_n, ep);
      for (int c = 0; c < stall; c++) begin
        start = poke_start;
        tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_selseg", selseg, es);
        chk("stall_idx", frame_idx, f);
        chk("stall_last", out_last, (f == eff - 1));
        chk_pix("stall_pix", pix, ep | wm);
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (f == eff - 1) begin
        chk("end_valid", out_valid, 0);
        chk("done_pulse", done, 1);
        chk("done_pulse_nowm", done_n, 1);
        chk("end_busy", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_stays", busy, 0);
      end else begin
        chk("no_done_mid_job", done, 0);
        chk("busy_mid_job", busy, 1);
      end
    end
  endtask

  initial begin
    logic [NPIX-1:0] wm1;
    int waited;
    rst = 1'b1; start = 1'b0; seed = '0; prob = '0; nframes = '0;
    msg = '0; watmk = '0; out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", frame_idx, 0);
    chk("rst_selseg", selseg, 0);
    chk_pix("rst_pix", pix, '0);
    chk_pix("rst_pix_nowm", pix_n, '0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Threshold 0 keeps every segment; single-frame job
    run_job(16'hACE1, 4'd0, 8'd1, rand_msg(), '0, 0, 1'b0);

    // Empty message over three frames
    run_job(16'h1234, 4'd4, 8'd3, '0, '0, 0, 1'b0);

    // Full message against the model, then seed 0 vs the substitute seed
    run_job(16'h0001, 4'd4, 8'd4, '1, '0, 0, 1'b0);
    run_job(16'h0000, 4'd4, 8'd2, '1, '0, 0, 1'b0);
    run_job(16'hACE1, 4'd9, 8'd0, rand_msg(), '0, 0, 1'b0);

    // Backpressure with start pulses while busy
    run_job(16'hBEEF, 4'd7, 8'd2, rand_msg(), rand_pix(), 5, 1'b1);

    // Single watermark pixel, everything else dark
    wm1 = '0;
    wm1[NPIX-1] = 1'b1;
    run_job(16'h5555, 4'd0, 8'd1, '0, wm1, 0, 1'b0);

    // Randomised jobs
    for (int j = 0; j < 4; j++) begin
      run_job(16'($urandom), 4'($urandom), 8'($urandom_range(1, 3)),
              rand_msg(), rand_pix(), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while generating the second frame aborts with no done pulse
    seed = 16'h0F0F; prob = 4'd3; nframes = 8'd3; msg = rand_msg(); watmk = rand_pix();
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 4 * NSEG) begin
      tick();
      waited++;
    end
    chk("abort_job_latency", waited, NSEG);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("abort_in_gen", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_selseg", selseg, 0);
    chk_pix("abort_pix", pix, '0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_no_done", done, 0);
    run_job(16'hC0DE, 4'd2, 8'd2, rand_msg(), rand_pix(), 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_frame_seq.md
Name: display_frame_seq

Overview:
- Sequential, parametrised successor to the combinational display top.
- Accepts one message and seed per job, then emits NB_FRAMES consecutive randomised display frames over a valid/ready stream.
- Each frame masks message segments with a clocked LFSR at a run-time probability, maps segments to pixels and optionally ORs in a watermark.
- Sits between the garbler-input loader and the frame serialiser.

Parameters:
- WIDTH, 120, display width in pixels.
- HEIGHT, 52, display height in pixels.
- NB_SEGMENTS, 120, number of bitmap segments in msg.
- RNDSIZE, 16, LFSR width; must be >= PROB_BITS + 1.
- PROB_BITS, 4, width of the probability threshold.
- FRAME_CNT_W, 8, width of the frame-count and frame-index fields.
- HAS_WATERMARK, 1, 1 = OR watmk into pix; 0 = ignore watmk.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- seed  in  RNDSIZE  LFSR seed, captured on start.
- prob  in  PROB_BITS  threshold, captured on start; 0 = all segments kept.
- nframes  in  FRAME_CNT_W  frames per job, captured on start; 0 is treated as 1.
- msg  in  NB_SEGMENTS  segment bitmap, captured on start.
- watmk  in  WIDTH*HEIGHT  watermark, captured on start.
- busy  out  1  high whenever not in IDLE.
- out_valid  out  1  frame available.
- out_ready  in  1  downstream accept.
- out_last  out  1  qualifies the final frame of a job.
- frame_idx  out  FRAME_CNT_W  0-based index of the presented frame.
- selseg  out  NB_SEGMENTS  masked segments of the presented frame.
- pix  out  WIDTH*HEIGHT  pixel frame.
- done  out  1  one-cycle pulse after the last frame is accepted.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy, out_valid, out_last and done are 0.
  - frame_idx, selseg and pix are 0.
  - LFSR and captured registers are 0.
- Reset has priority over all other events in every state; reset mid-GEN or mid-OUT aborts the job with no done pulse.
- FSM states: IDLE, GEN, OUT.
- IDLE:
  - On start=1, capture seed/prob/nframes/msg/watmk, clear seg_ptr and frame_idx, go to GEN.
  - A seed of 0 is replaced by the package constant LFSR_NONZERO_SEED.
- GEN (exactly NB_SEGMENTS cycles per frame):
  - Cycle k computes keep = (lfsr[PROB_BITS-1:0] >= prob).
  - It writes selseg_nxt[k] = msg[k] & keep, then advances the LFSR one step.
  - The LFSR is Fibonacci, shift-left, feedback = XOR of taps LFSR_TAPS(RNDSIZE) from the package.
  - After k = NB_SEGMENTS-1, register selseg, register pix, and go to OUT with out_valid=1.
- Latency: first out_valid rises NB_SEGMENTS+1 cycles after the start cycle.
- OUT:
  - selseg, pix, frame_idx and out_last stay stable while out_valid=1 and out_ready=0.
  - On the out_valid & out_ready cycle, if not last: frame_idx+1, seg_ptr=0, go to GEN.
  - On the out_valid & out_ready cycle, if last: out_valid=0 next cycle, done=1 for one cycle, go to IDLE.
  - out_last = (frame_idx == effective_nframes-1).
- The LFSR is not reseeded between frames; the sequence continues across frames.
- start is ignored while busy=1, and inputs changing while busy have no effect.
- pix = seg2pix(selseg) | (HAS_WATERMARK ? watmk_q : 0), registered at the GEN→OUT transition.
- Arithmetic:
  - frame_idx wraps never, since effective_nframes <= 2^FRAME_CNT_W-1.
  - The comparison is unsigned.
- done and start in the same cycle: FSM is in IDLE that cycle, so start is accepted and the new job begins.

Decomposition:
- Package display_pkg:
  - LFSR_TAPS function/table for widths 8..32.
  - LFSR_NONZERO_SEED.
  - FSM state enum {IDLE, GEN, OUT}.
  - Default WIDTH/HEIGHT/NB_SEGMENTS constants.
- Sub-module lfsr_step (combinational, RNDSIZE-parametrised next-state plus low-bits tap) is natural.
- The existing segment2pixel is reused as the combinational seg2pix instance.

Test Plan:
- Mask bypass and latency: NB_SEGMENTS=7, msg=7'b1011011, prob=0, nframes=1, seed=16'hACE1, out_ready=1 → out_valid at start+8, selseg=7'b1011011, out_last=1, done one cycle after the handshake.
- Zero message: msg=0, prob=4, nframes=3 → three frames, all with selseg=0, frame_idx 0,1,2, out_last only on idx 2, exactly one done pulse.
- Randomness against a model: seed=16'h0001, prob=4'b0100, msg=all-ones, nframes=4 → selseg matches the bit-accurate reference model per frame; seed=0 gives the same sequence as LFSR_NONZERO_SEED.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → selseg, pix, frame_idx and out_last are unchanged each cycle; the frame is accepted on cycle 6; start pulses during busy are ignored.
- Watermark: HAS_WATERMARK=1, prob=0, msg=0, watmk with a single pixel bit 6239 set → pix has only bit 6239 set; with HAS_WATERMARK=0 → pix=0.
- Reset mid-operation:
  - Assert rst at GEN cycle 3 of frame 1 → next cycle busy=0, out_valid=0, selseg=0, pix=0, no done pulse.
  - A new start then runs normally from frame_idx 0.
